map_ss_engine: RTL

- Save-state sequencer sitting directly upstream of every mapper's ss_ctrl port.
- Drives ss_act/ss_we/ss_addr and the substitute data byte that the top mux places on cpu_dat.
- Sweeps the mapper's save-state address space, capturing ss_rdat into a state buffer (save) or replaying buffer bytes into mapper registers on m2 falling edges (load).
- Runs on the system clock; m2 is sampled as an asynchronous input.

---
 rtl/map_ss_pkg.sv | 28 ++
 rtl/m2_edge_sync.sv | 30 +++
 rtl/map_ss_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/map_ss_pkg.sv
// ---------------------------------------------------------------------------
// map_ss_pkg: shared types and constants for the save-state engine.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package map_ss_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S_ADDR,
    ST_S_WAIT,
    ST_S_CAP,
    ST_L_CHK_RD,
    ST_L_CHK,
    ST_L_RD,
    ST_L_SET,
    ST_L_WAIT,
    ST_L_HOLD,
    ST_FIN,
    ST_ERR
  } ss_state_t;

  localparam int SS_IDX_ADDR       = 127;
  localparam int SS_M2_TIMEOUT_DEF = 4095;

endpackage

`default_nettype wire

// File: rtl/m2_edge_sync.sv
// ---------------------------------------------------------------------------
// m2_edge_sync: 2-FF synchronizer for M2 plus a one-clk falling-edge pulse.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m2_edge_sync (
  input  logic clk,
  input  logic sys_rst,
  input  logic m2,
  output logic m2_fall
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], m2};
      prev <= sync[1];
    end
  end

  assign m2_fall = prev & ~sync[1];

endmodule

`default_nettype wire

// File: rtl/map_ss_engine.sv
// ---------------------------------------------------------------------------
// map_ss_engine: sweeps a mapper's save-state space to/from a state buffer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module map_ss_engine
  import map_ss_pkg::*;
#(
  parameter int SS_LEN     = 128,
  parameter int IDX_ADDR   = SS_IDX_ADDR,
  parameter int SETTLE     = 2,
  parameter int M2_TIMEOUT = SS_M2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_wdat,
  output logic       buf_we,
  input  logic [7:0] buf_rdat,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_dat,
  input  logic [7:0] ss_rdat
);

  localparam logic [7:0]  LAST        = 8'(SS_LEN - 1);
  localparam logic [7:0]  IDX8        = 8'(IDX_ADDR);
  localparam logic [7:0]  FIRST_LD    = (IDX8 == 8'd0) ? 8'd1 : 8'd0;
  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE - 1);
  localparam logic [11:0] TIMEOUT     = 12'(M2_TIMEOUT);

  ss_state_t   state, state_nxt;
  logic [7:0]  n, n_nxt, n_inc, n_step;
  logic [11:0] cnt, cnt_nxt;
  logic        accept, last_ld, m2_fall;
  logic        err_q;
  logic [7:0]  ss_addr_q, ss_dat_q, buf_addr_q;

  m2_edge_sync u_m2_sync (
    .clk     (clk),
    .sys_rst (sys_rst),
    .m2      (m2),
    .m2_fall (m2_fall)
  );

  // Load walk skips the read-only index; the terminal test never relies on overflow.
  assign n_inc   = n + 8'd1;
  assign n_step  = (n_inc == IDX8) ? n + 8'd2 : n_inc;
  assign last_ld = (n == LAST) || ((n_inc == LAST) && (IDX8 == LAST));

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      n          <= 8'd0;
      cnt        <= 12'd0;
      err_q      <= 1'b0;
      ss_addr_q  <= 8'd0;
      ss_dat_q   <= 8'd0;
      buf_addr_q <= 8'd0;
    end else begin
      state      <= state_nxt;
      n          <= n_nxt;
      cnt        <= cnt_nxt;
      err_q      <= accept ? 1'b0 : err;
      ss_addr_q  <= ss_addr;
      ss_dat_q   <= ss_dat;
      buf_addr_q <= buf_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    busy      = 1'b0;
    ss_act    = 1'b0;
    ss_we     = 1'b0;
    done      = 1'b0;
    buf_we    = 1'b0;
    buf_wdat  = 8'd0;
    buf_addr  = buf_addr_q;
    ss_addr   = ss_addr_q;
    ss_dat    = ss_dat_q;
    err       = err_q;

    unique case (state)
      ST_IDLE: begin
        if (cmd_save) begin
          accept    = 1'b1;
          n_nxt     = 8'd0;
          state_nxt = ST_S_ADDR;
        end else if (cmd_load) begin
          accept    = 1'b1;
          state_nxt = ST_L_CHK_RD;
        end
      end
      ST_S_ADDR: begin
        cnt_nxt   = 12'd0;
        state_nxt = (SETTLE == 0) ? ST_S_CAP : ST_S_WAIT;
      end
      ST_S_WAIT: begin
        if (cnt == SETTLE_LAST) state_nxt = ST_S_CAP;
        else                    cnt_nxt   = cnt + 12'd1;
      end
      ST_S_CAP: begin
        buf_we   = 1'b1;
        buf_wdat = ss_rdat;
        buf_addr = n;
        if (n == LAST) begin
          state_nxt = ST_FIN;
        end else begin
          n_nxt     = n_inc;
          state_nxt = ST_S_ADDR;
        end
      end
      ST_L_CHK_RD: state_nxt = ST_L_CHK;
      ST_L_CHK: begin
        if (buf_rdat != ss_rdat) begin
          state_nxt = ST_ERR;
        end else begin
          n_nxt     = FIRST_LD;
          state_nxt = ST_L_RD;
        end
      end
      ST_L_RD: state_nxt = ST_L_SET;
      ST_L_SET: begin
        cnt_nxt   = 12'd0;
        state_nxt = ST_L_WAIT;
      end
      ST_L_WAIT: begin
        // A fall seen in the first wait clk left M2 before ss_we rose; wait for the next one.
        if (m2_fall && (cnt != 12'd0)) state_nxt = ST_L_HOLD;
        else if (cnt == TIMEOUT)       state_nxt = ST_ERR;
        else                           cnt_nxt   = cnt + 12'd1;
      end
      ST_L_HOLD: begin
        if (last_ld) begin
          state_nxt = ST_FIN;
        end else begin
          n_nxt     = n_step;
          state_nxt = ST_L_RD;
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state inside {ST_S_ADDR, ST_S_WAIT, ST_S_CAP, ST_L_CHK_RD, ST_L_CHK,
                      ST_L_RD, ST_L_SET, ST_L_WAIT, ST_L_HOLD}) begin
      busy   = 1'b1;
      ss_act = 1'b1;
    end
    if (state inside {ST_S_ADDR, ST_S_WAIT, ST_S_CAP, ST_L_SET, ST_L_WAIT, ST_L_HOLD})
      ss_addr = n;
    if (state inside {ST_L_CHK_RD, ST_L_CHK}) begin
      ss_addr  = IDX8;
      buf_addr = IDX8;
    end
    if (state inside {ST_L_RD, ST_L_SET, ST_L_WAIT, ST_L_HOLD})
      buf_addr = n;
    if (state inside {ST_L_SET, ST_L_WAIT, ST_L_HOLD})
      ss_we = 1'b1;
    if (state == ST_L_SET)
      ss_dat = buf_rdat;
  end

endmodule

`default_nettype wire
